mmuart_rx_deframer: RTL and testbench
=====================================

// Module: mmuart_rx_deframer
// PURPOSE
//  Fabric UART receiver on the serial line driven by the MSS MMUART_1_TXD output.
//  Samples the line at 16x oversampling and deframes 8N1 (or 8E1) characters.
//  Buffers received bytes in a small FIFO with a valid/ready interface for fabric logic.
//  Flags framing, parity and overrun errors as single-cycle pulses.
// PARAMETERS
//  BAUD_DIV    27  clocks per 1/16 bit tick (50 MHz / (16*115200)); legal range 2..65535
//  FIFO_DEPTH  8   byte FIFO entries; power of two, >= 2
// PORTS
//  MCCC_CLK_BASE  in   1                    single clock for the whole block
//  FAB_RESET      in   1                    reset: synchronous, active-high
//  RXD_IN         in   1                    serial line (MMUART_1_TXD); idle high; asynchronous
//  RX_DATA        out  8                    FIFO head byte; meaningful only while RX_VALID=1
//  RX_VALID       out  1                    FIFO not empty
//  RX_READY       in   1                    consumer accepts RX_DATA when RX_VALID & RX_READY
//  FRAME_ERR      out  1                    1-cycle pulse: stop bit sampled low
//  PARITY_ERR     out  1                    1-cycle pulse: parity mismatch (0 when macro off)
//  OVERRUN        out  1                    1-cycle pulse: good byte arrived with FIFO full
//  FIFO_LEVEL     out  $clog2(FIFO_DEPTH)+1 number of stored bytes
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE, both synchroniser flops and prev-sample set to 1.
//  - RXD_IN passes through a 2-flop synchroniser; all decisions use the synchronised value.
//  - Tick counter counts 0..BAUD_DIV-1 and emits a tick on BAUD_DIV-1. It is cleared on
//    IDLE->START so that start-bit sampling is phase-locked to the detected edge.
//  - FSM IDLE: enter START only on a 1->0 transition of the synchronised line. A line held
//    low (break, or after a frame error) never retriggers until it returns high.
//  - FSM START: after 8 ticks, sample the line. 1 -> IDLE (glitch, no flag); 0 -> DATA.
//  - FSM DATA: sample every 16 ticks, 8 bits, LSB first, into the shift register. Then go to
//    PARITY (macro on) or STOP.
//  - FSM STOP: sample after 16 ticks. 1 -> push byte; 0 -> FRAME_ERR pulse, byte dropped.
//    Both cases return to IDLE in the same cycle as the sample.
//  - Push: if the FIFO is full and no pop happens that cycle, pulse OVERRUN and drop the new
//    byte; FIFO contents are unchanged.
//  - Pop: occurs when RX_VALID & RX_READY. Simultaneous push+pop is always accepted, including
//    when full; FIFO_LEVEL is unchanged.
//  - Latency: RX_VALID and the new FIFO_LEVEL appear in the cycle after the stop-bit sample
//    cycle. RX_DATA is registered FIFO head data with no bypass path.
//  - Read and write pointers are $clog2(FIFO_DEPTH) bits wide and wrap naturally.
//  - Error pulses are mutually exclusive per frame and last exactly one cycle.
//  - FAB_RESET mid-frame abandons the frame and clears the FIFO. The first byte starting after
//    reset release is received normally.
// CONFIGURATION
//  MMUART_RX_PARITY_EN defined:
//    - Frame is 8E1. PARITY state samples one bit after 16 ticks.
//    - Parity is correct when the XOR of the 8 data bits and the parity bit is 0.
//    - On mismatch: after the stop bit is sampled, pulse PARITY_ERR and drop the byte.
//      FRAME_ERR takes priority if the stop bit is also low.
//  MMUART_RX_PARITY_EN undefined:
//    - Frame is 8N1, there is no PARITY state, and PARITY_ERR is tied to 0.
// TESTING  (BAUD_DIV=4 -> 64 clk/bit, FIFO_DEPTH=8)
//  1. Drive 8N1 frame 0xA5 -> RX_DATA=0xA5, RX_VALID=1, FIFO_LEVEL=1; no error pulses.
//     With RX_READY=1, FIFO_LEVEL returns to 0 one cycle later.
//  2. Drive a 20-clk low glitch on an idle line -> START aborts at 32 clks.
//     No RX_VALID, no error pulse, FSM returns to IDLE.
//  3. Drive 0x3C with the stop bit low, then hold the line low for 10 bits -> one FRAME_ERR
//     pulse, FIFO_LEVEL=0, no further frames detected until the line goes high.
//  4. With RX_READY=0, send 0x00..0x08 -> FIFO_LEVEL=8 and one OVERRUN pulse on 0x08.
//     Then RX_READY=1 drains 0x00..0x07 in order; a pop at full concurrent with a push
//     keeps FIFO_LEVEL=8 with no OVERRUN.
//  5. Pulse FAB_RESET for 1 clk after the 4th data bit of 0xFF -> no output, FIFO_LEVEL=0.
//     The following frame 0x5A is received correctly.
//  6. MMUART_RX_PARITY_EN defined: send 0x01 with parity bit 1 -> byte accepted.
//     Send 0x01 with parity bit 0 -> one PARITY_ERR pulse, byte dropped.
//     Macro undefined: PARITY_ERR stays 0 throughout.

Source files
------------

// File: rtl/mmuart_rx_deframer.sv
// mmuart_rx_deframer
//   Fabric-side UART receiver for the MSS MMUART_1_TXD line. Oversamples the
//   line at 16x, deframes 8N1 characters (8E1 when MMUART_RX_PARITY_EN is
//   defined) and queues good bytes in a small FIFO with a valid/ready port.
//
//   Build option: `define MMUART_RX_PARITY_EN  -> 8E1 framing with even parity
//   checking; otherwise 8N1 and PARITY_ERR is tied to 0.
//
// Ports
//   MCCC_CLK_BASE  in   clock
//   FAB_RESET      in   synchronous active-high reset
//   RXD_IN         in   asynchronous serial line, idle high
//   RX_DATA        out  FIFO head byte (meaningful while RX_VALID)
//   RX_VALID       out  FIFO not empty
//   RX_READY       in   consumer accepts head when RX_VALID & RX_READY
//   FRAME_ERR      out  1-cycle pulse, stop bit sampled low
//   PARITY_ERR     out  1-cycle pulse, parity mismatch
//   OVERRUN        out  1-cycle pulse, good byte dropped because FIFO full
//   FIFO_LEVEL     out  stored byte count
module mmuart_rx_deframer #(
  parameter int BAUD_DIV   = 27,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        MCCC_CLK_BASE,
  input  logic                        FAB_RESET,
  input  logic                        RXD_IN,
  output logic [7:0]                  RX_DATA,
  output logic                        RX_VALID,
  input  logic                        RX_READY,
  output logic                        FRAME_ERR,
  output logic                        PARITY_ERR,
  output logic                        OVERRUN,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL
);
  localparam int          AW       = $clog2(FIFO_DEPTH);
  localparam int          LW       = AW + 1;
  localparam logic [15:0] TICK_MAX = 16'(BAUD_DIV - 1);

`ifdef MMUART_RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t          state, nxt;
  logic            sync1, sync2, prev;
  logic            rxd, fall;
  logic [15:0]     tcnt;
  logic            tick;
  logic [3:0]      tk;       // ticks elapsed in the current bit
  logic            samp;     // bit-sample strobe for the current state
  logic [2:0]      bcnt;
  logic [7:0]      sh;
  logic            start_go, push, ferr_set;
`ifdef MMUART_RX_PARITY_EN
  logic            par_bad, perr_set;
`endif

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wptr, rptr;
  logic [LW-1:0]   level;
  logic            full, pop, wr;

  // Two-flop synchroniser plus one history flop for edge detection.
  // Reset to 1 so a held-high line never looks like a start edge.
  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      prev  <= 1'b1;
    end else begin
      sync1 <= RXD_IN;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rxd  = sync2;
  assign fall = prev & ~rxd;
  assign tick = (tcnt == TICK_MAX);
  // Start bit is sampled at its middle (8 ticks), all later bits 16 ticks apart.
  assign samp = tick & (tk == ((state == S_START) ? 4'd7 : 4'd15));

  // Tick/bit counters and shift register. Clearing on start_go locks the
  // sampling phase to the detected falling edge.
  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET) begin
      tcnt <= '0;
      tk   <= '0;
      bcnt <= '0;
      sh   <= '0;
    end else begin
      if (start_go || tick) tcnt <= '0;
      else                  tcnt <= tcnt + 16'd1;
      if (start_go || samp) tk <= '0;
      else if (tick)        tk <= tk + 4'd1;
      if (start_go)
        bcnt <= '0;
      else if (state == S_DATA && samp) begin
        bcnt <= bcnt + 3'd1;
        sh   <= {rxd, sh[7:1]};  // LSB first
      end
    end
  end

`ifdef MMUART_RX_PARITY_EN
  // Even parity: data XOR parity bit must be 0.
  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET)                        par_bad <= 1'b0;
    else if (state == S_PARITY && samp)   par_bad <= ^{sh, rxd};
  end
`endif

  // FSM state register
  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET) state <= S_IDLE;
    else           state <= nxt;
  end

  // FSM next state
  always_comb begin
    nxt = state;
    case (state)
      S_IDLE:   if (fall) nxt = S_START;
      S_START:  if (samp) nxt = rxd ? S_IDLE : S_DATA;
`ifdef MMUART_RX_PARITY_EN
      S_DATA:   if (samp && bcnt == 3'd7) nxt = S_PARITY;
      S_PARITY: if (samp) nxt = S_STOP;
`else
      S_DATA:   if (samp && bcnt == 3'd7) nxt = S_STOP;
`endif
      S_STOP:   if (samp) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // FSM outputs: one strobe per frame outcome at the stop-bit sample
  always_comb begin
    start_go = 1'b0;
    push     = 1'b0;
    ferr_set = 1'b0;
`ifdef MMUART_RX_PARITY_EN
    perr_set = 1'b0;
`endif
    case (state)
      S_IDLE: start_go = fall;
      S_STOP:
        if (samp) begin
          if (!rxd)        ferr_set = 1'b1;
`ifdef MMUART_RX_PARITY_EN
          else if (par_bad) perr_set = 1'b1;
`endif
          else             push     = 1'b1;
        end
      default: ;
    endcase
  end

  // FIFO. Pop is evaluated first, so a push while full is still accepted
  // when a pop frees the slot in the same cycle.
  assign full = (level == LW'(FIFO_DEPTH));
  assign pop  = RX_VALID & RX_READY;
  assign wr   = push & (~full | pop);

  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) begin
        mem[wptr] <= sh;
        wptr      <= wptr + AW'(1);
      end
      if (pop) rptr <= rptr + AW'(1);
      case ({wr, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: ;
      endcase
    end
  end

  assign RX_DATA    = mem[rptr];
  assign RX_VALID   = (level != '0);
  assign FIFO_LEVEL = level;

  // Error pulses, registered so they line up with the FIFO update
  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET) begin
      FRAME_ERR <= 1'b0;
      OVERRUN   <= 1'b0;
    end else begin
      FRAME_ERR <= ferr_set;
      OVERRUN   <= push & full & ~pop;
    end
  end

`ifdef MMUART_RX_PARITY_EN
  always_ff @(posedge MCCC_CLK_BASE) begin
    if (FAB_RESET) PARITY_ERR <= 1'b0;
    else           PARITY_ERR <= perr_set;
  end
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_mmuart_rx_deframer.sv
// tb_mmuart_rx_deframer
//   Randomised + directed bench for mmuart_rx_deframer (BAUD_DIV=4 -> 64
//   clk/bit, FIFO_DEPTH=8). A transaction-level model (byte queue plus frame
//   outcome scheduled at the stop-bit commit cycle) predicts the FIFO and the
//   error pulses; every cycle the DUT outputs are compared against it.
module tb_mmuart_rx_deframer;
  localparam int DEPTH = 8;
  localparam int BIT   = 64;
`ifdef MMUART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = PAR_EN ? 10 : 9;  // bits before the stop bit
  localparam int K_GOOD = 0, K_FERR = 1, K_PERR = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxd = 1'b1;
  logic       rdy = 1'b0;
  logic [7:0] data;
  logic       valid, ferr, perr, ovr;
  logic [3:0] level;

  int         cyc = 0;
  int         commit_cyc = -1;
  int         pend_kind = K_GOOD;
  logic [7:0] pend_d = '0;
  logic [7:0] q[$];
  bit         e_ferr, e_perr, e_ovr;
  bit         mon_en = 1'b0;
  int         rdy_mode = 0;  // 0 off, 1 on, 2 random, 3 only at commit
  int         n_chk = 0, n_err = 0;

  mmuart_rx_deframer #(.BAUD_DIV(4), .FIFO_DEPTH(DEPTH)) dut (
    .MCCC_CLK_BASE(clk),
    .FAB_RESET    (rst),
    .RXD_IN       (rxd),
    .RX_DATA      (data),
    .RX_VALID     (valid),
    .RX_READY     (rdy),
    .FRAME_ERR    (ferr),
    .PARITY_ERR   (perr),
    .OVERRUN      (ovr),
    .FIFO_LEVEL   (level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: commits a frame outcome at the cycle the spec places
  // the registered result (stop-bit middle + 2 sync flops + 1 register).
  initial forever begin
    @(posedge clk);
    cyc++;
    e_ferr = 1'b0;
    e_perr = 1'b0;
    e_ovr  = 1'b0;
    if (rst) begin
      q.delete();
      commit_cyc = -1;
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (cyc == commit_cyc) begin
        case (pend_kind)
          K_FERR:  e_ferr = 1'b1;
          K_PERR:  e_perr = 1'b1;
          default: if (q.size() == DEPTH) e_ovr = 1'b1;
                   else q.push_back(pend_d);
        endcase
      end
    end
  end

  // Per-cycle comparison, away from the active edge
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      chk("valid", 32'(valid), 32'(q.size() != 0));
      chk("level", 32'(level), 32'(q.size()));
      if (q.size() != 0) chk("data", 32'(data), 32'(q[0]));
      chk("frame_err", 32'(ferr), 32'(e_ferr));
      chk("parity_err", 32'(perr), 32'(e_perr));
      chk("overrun", 32'(ovr), 32'(e_ovr));
    end
  end

  // Consumer
  initial forever begin
    @(negedge clk);
    case (rdy_mode)
      1:       rdy = 1'b1;
      2:       rdy = ($urandom_range(0, 3) == 0);
      3:       rdy = (cyc + 1 == commit_cyc);
      default: rdy = 1'b0;
    endcase
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One frame; leaves the line at the stop-bit level.
  task automatic send(input logic [7:0] d, input bit stop, input bit pbad);
    @(negedge clk);
    pend_d     = d;
    pend_kind  = !stop ? K_FERR : (PAR_EN && pbad) ? K_PERR : K_GOOD;
    commit_cyc = cyc + BIT * NB + 35;
    rxd = 1'b0;
    idle(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      idle(BIT);
    end
    if (PAR_EN) begin
      rxd = (^d) ^ pbad;
      idle(BIT);
    end
    rxd = stop;
    idle(BIT);
  endtask

  initial begin
    idle(3);
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_level", 32'(level), 32'h0);
    chk("rst_ferr", 32'(ferr), 32'h0);
    chk("rst_perr", 32'(perr), 32'h0);
    chk("rst_ovr", 32'(ovr), 32'h0);
    rst    = 1'b0;
    mon_en = 1'b1;
    idle(10);

    // basic frame, then drain
    send(8'hA5, 1'b1, 1'b0);
    idle(20);
    chk("a5_level", 32'(level), 32'd1);
    chk("a5_data", 32'(data), 32'hA5);
    rdy_mode = 1;
    idle(5);
    chk("a5_drained", 32'(level), 32'd0);

    // short low glitch must not produce a frame
    @(negedge clk);
    rxd = 1'b0;
    idle(20);
    rxd = 1'b1;
    idle(100);

    // framing error followed by a long break
    send(8'h3C, 1'b0, 1'b0);
    idle(10 * BIT);
    rxd = 1'b1;
    idle(128);
    chk("brk_level", 32'(level), 32'd0);

    // fill, overrun, pop-at-full concurrent with push, drain
    rdy_mode = 0;
    for (int i = 0; i < 9; i++) send(8'(i), 1'b1, 1'b0);
    idle(10);
    chk("full_level", 32'(level), 32'd8);
    rdy_mode = 3;
    send(8'h09, 1'b1, 1'b0);
    idle(10);
    chk("pushpop_level", 32'(level), 32'd8);
    rdy_mode = 1;
    idle(20);

    // reset mid-frame with a byte already queued
    rdy_mode = 0;
    send(8'h11, 1'b1, 1'b0);
    @(negedge clk);
    rxd = 1'b0;
    idle(BIT);
    rxd = 1'b1;
    idle(4 * BIT);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(6 * BIT);
    chk("rst_mid_level", 32'(level), 32'd0);
    send(8'h5A, 1'b1, 1'b0);
    idle(10);
    chk("post_rst_data", 32'(data), 32'h5A);
    rdy_mode = 1;
    idle(10);

    // parity cases (plain good frames in an 8N1 build)
    send(8'h01, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b1);
    send(8'h55, 1'b0, 1'b1);
    idle(30);
    rxd = 1'b1;
    idle(64);

    // randomised traffic with a random consumer
    rdy_mode = 2;
    for (int f = 0; f < 14; f++) begin
      logic [7:0] d;
      int         r;
      d = 8'($urandom);
      r = $urandom_range(0, 7);
      send(d, r != 0, r == 1);
      if (r == 0) begin
        idle($urandom_range(0, 100));
        rxd = 1'b1;
        idle(20);
      end
      idle($urandom_range(0, 40));
    end

    rdy_mode = 1;
    idle(50);
    chk("final_level", 32'(level), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
